// File: rtl/wt_cache_ctrl.sv
// wt_cache_ctrl: direct-mapped, write-through, write-allocate cache controller
// between the CPU sequencer and a single-port synchronous RAM (one-cycle read).
//
// Ports:
//   clk, rst_n          system clock (rising edge), synchronous active-low reset
//   cpu_req/we/addr/wdata  request handshake, fields captured when accepted in IDLE
//   cpu_rdata/ready/hit    completion: one-cycle ready pulse with data and lookup result
//   cpu_busy            controller is not in IDLE
//   flush               invalidate every line (acted on in IDLE only)
//   mem_cs/we/oe/addr/wdata  RAM controls and write data; mem_rdata RAM read data
//   hit_count/miss_count     saturating lookup statistics
//
// state    | meaning
// IDLE     | waiting for cpu_req or flush
// LOOKUP   | tag compare on captured address; store writes line and starts RAM write
// MEM_RD   | RAM read command held while RAM samples the address
// MEM_WAIT | RAM data arrives; fill line and complete load
// MEM_WR   | RAM write done; complete store
module wt_cache_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_hit,
    output logic                  cpu_busy,
    input  logic                  flush,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR} state_t;

    state_t                r_state, w_state_nx;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    logic [DATA_WIDTH-1:0] r_cpu_rdata, w_cpu_rdata_nx;
    logic                  r_cpu_ready, w_cpu_ready_nx;
    logic                  r_cpu_hit, w_cpu_hit_nx;
    logic                  r_cpu_busy;
    logic                  r_mem_cs, w_mem_cs_nx;
    logic                  r_mem_we, w_mem_we_nx;
    logic                  r_mem_oe, w_mem_oe_nx;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nx;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nx;
    logic [15:0]           r_hit_count, w_hit_count_nx;
    logic [15:0]           r_miss_count, w_miss_count_nx;

    logic                  w_accept;
    logic                  w_flush;
    logic                  w_line_we;
    logic [DATA_WIDTH-1:0] w_line_data;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;

    assign w_index = r_addr[INDEX_BITS-1:0];
    assign w_tag   = r_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

    always_comb begin
        w_state_nx      = r_state;
        w_cpu_rdata_nx  = r_cpu_rdata;
        w_cpu_ready_nx  = 1'b0;
        w_cpu_hit_nx    = r_cpu_hit;
        w_mem_cs_nx     = r_mem_cs;
        w_mem_we_nx     = r_mem_we;
        w_mem_oe_nx     = r_mem_oe;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_wdata_nx  = r_mem_wdata;
        w_hit_count_nx  = r_hit_count;
        w_miss_count_nx = r_miss_count;
        w_accept        = 1'b0;
        w_flush         = 1'b0;
        w_line_we       = 1'b0;
        w_line_data     = r_wdata;

        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_flush = 1'b1;
                end else if (cpu_req) begin
                    w_accept   = 1'b1;
                    w_state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                w_cpu_hit_nx = w_hit;
                if (w_hit) begin
                    w_hit_count_nx = (r_hit_count == 16'hFFFF) ? r_hit_count : r_hit_count + 16'd1;
                end else begin
                    w_miss_count_nx = (r_miss_count == 16'hFFFF) ? r_miss_count : r_miss_count + 16'd1;
                end
                if (r_we) begin
                    // allocate on every store, hit or not
                    w_line_we      = 1'b1;
                    w_line_data    = r_wdata;
                    w_mem_cs_nx    = 1'b1;
                    w_mem_we_nx    = 1'b1;
                    w_mem_oe_nx    = 1'b0;
                    w_mem_addr_nx  = r_addr;
                    w_mem_wdata_nx = r_wdata;
                    w_state_nx     = MEM_WR;
                end else if (w_hit) begin
                    w_cpu_rdata_nx = r_data[w_index];
                    w_cpu_ready_nx = 1'b1;
                    w_state_nx     = IDLE;
                end else begin
                    w_mem_cs_nx   = 1'b1;
                    w_mem_we_nx   = 1'b0;
                    w_mem_oe_nx   = 1'b1;
                    w_mem_addr_nx = r_addr;
                    w_state_nx    = MEM_RD;
                end
            end
            MEM_RD: begin
                w_state_nx = MEM_WAIT;
            end
            MEM_WAIT: begin
                w_line_we      = 1'b1;
                w_line_data    = mem_rdata;
                w_cpu_rdata_nx = mem_rdata;
                w_cpu_ready_nx = 1'b1;
                w_cpu_hit_nx   = 1'b0;
                w_mem_cs_nx    = 1'b0;
                w_mem_oe_nx    = 1'b0;
                w_state_nx     = IDLE;
            end
            MEM_WR: begin
                w_mem_cs_nx    = 1'b0;
                w_mem_we_nx    = 1'b0;
                w_cpu_ready_nx = 1'b1;
                w_state_nx     = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_valid      <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_ready  <= 1'b0;
            r_cpu_hit    <= 1'b0;
            r_cpu_busy   <= 1'b0;
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_oe     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cpu_rdata  <= w_cpu_rdata_nx;
            r_cpu_ready  <= w_cpu_ready_nx;
            r_cpu_hit    <= w_cpu_hit_nx;
            r_cpu_busy   <= (w_state_nx != IDLE);
            r_mem_cs     <= w_mem_cs_nx;
            r_mem_we     <= w_mem_we_nx;
            r_mem_oe     <= w_mem_oe_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_wdata  <= w_mem_wdata_nx;
            r_hit_count  <= w_hit_count_nx;
            r_miss_count <= w_miss_count_nx;
            if (w_accept) begin
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
            if (w_flush) begin
                r_valid <= '0;
            end else if (w_line_we) begin
                r_valid[w_index] <= 1'b1;
            end
        end
    end

    // Tag/data contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && w_line_we) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= w_line_data;
        end
    end

    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ready  = r_cpu_ready;
    assign cpu_hit    = r_cpu_hit;
    assign cpu_busy   = r_cpu_busy;
    assign mem_cs     = r_mem_cs;
    assign mem_we     = r_mem_we;
    assign mem_oe     = r_mem_oe;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: doc/wt_cache_ctrl.md
Name: wt_cache_ctrl

Overview:
Direct-mapped, write-through, write-allocate cache controller that sits between the CPU sequencer and the single-port synchronous RAM. It sequences the lookup, miss fill and write-through traffic. It owns the tag/valid/data arrays and generates the RAM cs/we/oe/addr controls. The top level converts the RAM's tristate data bus into split mem_wdata/mem_rdata. It also keeps hit/miss statistics for the test bench.

Parameters:
ADDR_WIDTH, 14, word address width (matches RAM)
DATA_WIDTH, 16, word width
INDEX_BITS, 4, line index width; 2**INDEX_BITS one-word lines; TAG = ADDR_WIDTH-INDEX_BITS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  request; sampled only in IDLE
cpu_we  in  1  1=store, 0=load; captured with req
cpu_addr  in  ADDR_WIDTH  word address; captured with req
cpu_wdata  in  DATA_WIDTH  store data; captured with req
cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  lookup result of the completing access, valid with cpu_ready
cpu_busy  out  1  state != IDLE
flush  in  1  invalidate all lines (IDLE only)
mem_cs, mem_we, mem_oe  out  1 each  RAM controls
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  DATA_WIDTH  RAM write data (top drives bus when mem_oe=0)
mem_rdata  in  DATA_WIDTH  RAM read data
hit_count, miss_count  out  16 each  saturating statistics counters

Behaviour:
- All outputs are registered. Reset (rst_n low at an edge) sets state=IDLE, clears every valid bit, zeroes all outputs and both counters, and abandons any access in flight. mem_we is 0 from that edge on. Tag/data arrays are not cleared.
- Address split: index=addr[INDEX_BITS-1:0], tag=addr[ADDR_WIDTH-1:INDEX_BITS]. Hit = valid[index] && tag match.
- States: IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR.
- IDLE:
  - flush=1: clear all valid bits at this edge and stay IDLE. Flush has priority over cpu_req, and a simultaneous req is not accepted.
  - else cpu_req=1: latch we/addr/wdata, go to LOOKUP.
- LOOKUP, load hit: cpu_rdata<=line, cpu_hit<=1, cpu_ready<=1, hit_count++, go to IDLE.
- LOOKUP, load miss: mem_cs=1, mem_oe=1, mem_we=0, mem_addr=addr, go to MEM_RD; miss_count++.
- MEM_RD: hold the controls, go to MEM_WAIT (RAM samples the address this edge).
- MEM_WAIT: capture mem_rdata into the line (valid=1, tag) and into cpu_rdata. Pulse cpu_ready with cpu_hit=0. Drop mem_cs/mem_oe. Go to IDLE.
- LOOKUP, store (write-through, allocate regardless of hit):
  - Write line data/tag and set valid=1.
  - Drive mem_cs=1, mem_we=1, mem_oe=0, mem_addr, mem_wdata=wdata.
  - Count a hit or miss as for loads; cpu_hit reflects the pre-write lookup. Go to MEM_WR.
- MEM_WR: drop mem_we/mem_cs, pulse cpu_ready, go to IDLE.
- Latency from the edge that samples cpu_req to cpu_ready visible: load hit 2 edges, store 3 edges, load miss 4 edges.
- cpu_ready is high for exactly one cycle while the state is already IDLE. If cpu_req is high in that cycle, it is a new accepted request (back-to-back supported). The CPU must drop req in that cycle if it has no new request.
- cpu_req outside IDLE is ignored. Captured fields are stable for the whole access.
- Outside accesses mem_cs=mem_we=mem_oe=0, and mem_addr/mem_wdata hold their last value.
- Counters saturate at 0xFFFF.
- Conflict (same index, different tag): a load miss replaces the line; a store replaces the line.

Test Plan:
- Reset, then load 0x105 with RAM[0x105]=0x1234: miss, mem_oe asserted 2 cycles, cpu_rdata=0x1234, cpu_hit=0, ready 4 edges after req, miss_count=1.
- Repeat load 0x105: cpu_hit=1, rdata=0x1234, no mem_cs activity, ready after 2 edges, hit_count=1.
- Store 0xBEEF to 0x205 (same index, tag 0x20): mem_we one cycle with addr 0x205 and data 0xBEEF. Then load 0x205 hits 0xBEEF, and load 0x105 misses and refetches 0x1234.
- Back-to-back: hold cpu_req high across ready with two loads to 0x105: the second is accepted in the ready cycle and completes 2 edges later.
- Flush and cpu_req together in IDLE: no access starts. Next-cycle load 0x105 misses (valid cleared).
- Assert rst_n=0 during MEM_RD of a miss: next edge state IDLE, mem_cs=0, no cpu_ready. Counters 0; subsequent load 0x105 misses.
